// File: rtl/prog_loader.sv
// Byte-stream loader: parses framed packets and writes instruction ROM or data memory,
// holding the core in reset while a load is in flight.
`timescale 1ns/1ps
module prog_loader #(
    parameter int unsigned IADDR_W = 16,
    parameter int unsigned DADDR_W = 8,
    parameter logic [7:0]  HDR     = 8'hA5
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               rx_valid,
    input  logic [7:0]         rx_data,
    output logic               rx_ready,
    output logic               irom_wr_en,
    output logic [IADDR_W-1:0] irom_addr,
    output logic [8:0]         irom_wr_data,
    output logic               dmem_wr_en,
    output logic [DADDR_W-1:0] dmem_addr,
    output logic [7:0]         dmem_wr_data,
    output logic               core_hold,
    output logic               done,
    output logic               err
);

    typedef enum logic [3:0] {
        StIdle, StTgt, StCntHi, StCntLo, StPayHi, StPayLo, StChk, StDone, StErr
    } state_e;

    state_e               state_q, state_d;
    logic                 is_dmem_q, is_dmem_d;
    logic [7:0]           cnt_hi_q, cnt_hi_d;
    logic [15:0]          cnt_q, cnt_d;
    logic [IADDR_W-1:0]   addr_q, addr_d;
    logic [7:0]           xor_q, xor_d;
    logic                 hi_bit_q, hi_bit_d;
    logic                 hold_q, hold_d;
    logic                 irom_wr_en_q, irom_wr_en_d;
    logic [IADDR_W-1:0]   irom_addr_q, irom_addr_d;
    logic [8:0]           irom_wr_data_q, irom_wr_data_d;
    logic                 dmem_wr_en_q, dmem_wr_en_d;
    logic [DADDR_W-1:0]   dmem_addr_q, dmem_addr_d;
    logic [7:0]           dmem_wr_data_q, dmem_wr_data_d;
    logic                 xfer;

    assign rx_ready = RESET && (state_q != StDone) && (state_q != StErr);
    assign xfer     = rx_valid && rx_ready;

    always_comb begin
        state_d        = state_q;
        is_dmem_d      = is_dmem_q;
        cnt_hi_d       = cnt_hi_q;
        cnt_d          = cnt_q;
        addr_d         = addr_q;
        xor_d          = xor_q;
        hi_bit_d       = hi_bit_q;
        hold_d         = hold_q;
        irom_wr_en_d   = 1'b0;
        irom_addr_d    = irom_addr_q;
        irom_wr_data_d = irom_wr_data_q;
        dmem_wr_en_d   = 1'b0;
        dmem_addr_d    = dmem_addr_q;
        dmem_wr_data_d = dmem_wr_data_q;
        unique case (state_q)
            StIdle: begin
                if (xfer && rx_data == HDR) begin
                    state_d = StTgt;
                    hold_d  = 1'b1;
                end
            end
            StTgt: begin
                if (xfer) begin
                    if (rx_data == 8'h00 || rx_data == 8'h01) begin
                        is_dmem_d = rx_data[0];
                        state_d   = StCntHi;
                    end else begin
                        state_d = StErr;
                    end
                end
            end
            StCntHi: begin
                if (xfer) begin
                    cnt_hi_d = rx_data;
                    state_d  = StCntLo;
                end
            end
            StCntLo: begin
                if (xfer) begin
                    cnt_d  = {cnt_hi_q, rx_data};
                    addr_d = '0;
                    xor_d  = 8'h00;
                    if ({cnt_hi_q, rx_data} == 16'h0000) state_d = StChk;
                    else if (is_dmem_q)                  state_d = StPayLo;
                    else                                 state_d = StPayHi;
                end
            end
            StPayHi: begin
                if (xfer) begin
                    hi_bit_d = rx_data[0];
                    xor_d    = xor_q ^ rx_data;
                    state_d  = StPayLo;
                end
            end
            StPayLo: begin
                if (xfer) begin
                    xor_d  = xor_q ^ rx_data;
                    addr_d = addr_q + IADDR_W'(1);
                    cnt_d  = cnt_q - 16'd1;
                    if (is_dmem_q) begin
                        dmem_wr_en_d   = 1'b1;
                        dmem_addr_d    = addr_q[DADDR_W-1:0];
                        dmem_wr_data_d = rx_data;
                    end else begin
                        irom_wr_en_d   = 1'b1;
                        irom_addr_d    = addr_q;
                        irom_wr_data_d = {hi_bit_q, rx_data};
                    end
                    if (cnt_q == 16'd1) state_d = StChk;
                    else if (is_dmem_q) state_d = StPayLo;
                    else                state_d = StPayHi;
                end
            end
            StChk: begin
                if (xfer) begin
                    if (rx_data == xor_q) begin
                        state_d = StDone;
                        hold_d  = 1'b0;
                    end else begin
                        state_d = StErr;
                    end
                end
            end
            StDone, StErr: state_d = StIdle;
            default:       state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q        <= StIdle;
            is_dmem_q      <= 1'b0;
            cnt_hi_q       <= 8'h00;
            cnt_q          <= 16'h0000;
            addr_q         <= '0;
            xor_q          <= 8'h00;
            hi_bit_q       <= 1'b0;
            hold_q         <= 1'b0;
            irom_wr_en_q   <= 1'b0;
            irom_addr_q    <= '0;
            irom_wr_data_q <= 9'h000;
            dmem_wr_en_q   <= 1'b0;
            dmem_addr_q    <= '0;
            dmem_wr_data_q <= 8'h00;
        end else begin
            state_q        <= state_d;
            is_dmem_q      <= is_dmem_d;
            cnt_hi_q       <= cnt_hi_d;
            cnt_q          <= cnt_d;
            addr_q         <= addr_d;
            xor_q          <= xor_d;
            hi_bit_q       <= hi_bit_d;
            hold_q         <= hold_d;
            irom_wr_en_q   <= irom_wr_en_d;
            irom_addr_q    <= irom_addr_d;
            irom_wr_data_q <= irom_wr_data_d;
            dmem_wr_en_q   <= dmem_wr_en_d;
            dmem_addr_q    <= dmem_addr_d;
            dmem_wr_data_q <= dmem_wr_data_d;
        end
    end

    assign irom_wr_en   = irom_wr_en_q;
    assign irom_addr    = irom_addr_q;
    assign irom_wr_data = irom_wr_data_q;
    assign dmem_wr_en   = dmem_wr_en_q;
    assign dmem_addr    = dmem_addr_q;
    assign dmem_wr_data = dmem_wr_data_q;
    assign core_hold    = hold_q;
    assign done         = (state_q == StDone);
    assign err          = (state_q == StErr);

endmodule
